// File: rtl/div_fu_ctrl_if.sv
// Reservation-station request and CDB response channels of the divide unit controller.
// master = producer/consumer side (RS + CDB arbiter), slave = div_fu_ctrl.
interface div_fu_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/div_fu_ctrl.sv
// Issue/collect controller for a fixed-latency unsigned divider: sign handling,
// RISC-V special cases, metadata pipe and an in-order credit-managed result buffer.
module div_fu_ctrl #(
    parameter int XLEN      = 32,
    parameter int DIV_LAT   = 3,
    parameter int TAG_W     = 6,
    parameter int RES_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    div_fu_ctrl_if.slave    bus,
    output logic [XLEN-1:0] o_div_a,
    output logic [XLEN-1:0] o_div_b,
    input  logic [XLEN-1:0] i_div_quotient,
    input  logic [XLEN-1:0] i_div_remainder,
    input  logic            i_div_by_0
);
    localparam int OCC_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [XLEN-1:0] XONE = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] XALL = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XZERO = {XLEN{1'b0}};

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic             rem;
        logic             neg_q;
        logic             neg_r;
        logic             sp;
        logic [XLEN-1:0]  sp_val;
    } meta_t;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } res_t;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] x);
        return ~x + XONE;
    endfunction

    meta_t            r_pipe [DIV_LAT];
    res_t             r_mem  [RES_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_cnt;
    logic [OCC_W-1:0] r_occ;

    logic             w_accept;
    logic             w_signed;
    logic             w_push;
    logic             w_pop;
    meta_t            w_issue;
    logic [XLEN-1:0]  w_result;
    logic             w_unused;

    // The divider's own zero flag is redundant: zero divisors are resolved at issue.
    assign w_unused = i_div_by_0;

    assign bus.req_ready  = (r_occ < OCC_W'(RES_DEPTH)) & ~i_flush;
    assign w_accept       = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = (r_cnt != {OCC_W{1'b0}});
    assign bus.resp_data  = bus.resp_valid ? r_mem[r_rptr].data : XZERO;
    assign bus.resp_tag   = bus.resp_valid ? r_mem[r_rptr].tag : {TAG_W{1'b0}};
    assign w_push         = r_pipe[DIV_LAT-1].vld & ~i_flush;
    assign w_pop          = bus.resp_valid & bus.resp_ready & ~i_flush;

    // Issue-side conditioning: magnitudes, sign flags and special-case results.
    always_comb begin
        w_signed       = ~bus.req_op[0];
        w_issue.vld    = w_accept;
        w_issue.tag    = bus.req_tag;
        w_issue.rem    = bus.req_op[1];
        w_issue.neg_q  = w_signed & (bus.req_rs1[XLEN-1] ^ bus.req_rs2[XLEN-1]);
        w_issue.neg_r  = w_signed & bus.req_rs1[XLEN-1];
        w_issue.sp     = 1'b0;
        w_issue.sp_val = XZERO;
        if (w_signed && bus.req_rs1[XLEN-1]) begin
            o_div_a = f_neg(bus.req_rs1);
        end else begin
            o_div_a = bus.req_rs1;
        end
        if (w_signed && bus.req_rs2[XLEN-1]) begin
            o_div_b = f_neg(bus.req_rs2);
        end else begin
            o_div_b = bus.req_rs2;
        end
        if (bus.req_rs2 == XZERO) begin
            w_issue.sp     = 1'b1;
            w_issue.sp_val = bus.req_op[1] ? bus.req_rs1 : XALL;
        end else if (w_signed && (bus.req_rs1 == XMIN) && (bus.req_rs2 == XALL)) begin
            w_issue.sp     = 1'b1;
            w_issue.sp_val = bus.req_op[1] ? XZERO : XMIN;
        end else begin
            w_issue.sp     = 1'b0;
        end
    end

    // Sign fix-up of the divider output for the op leaving the metadata pipe.
    always_comb begin
        w_result = i_div_quotient;
        if (r_pipe[DIV_LAT-1].sp) begin
            w_result = r_pipe[DIV_LAT-1].sp_val;
        end else if (r_pipe[DIV_LAT-1].rem) begin
            w_result = r_pipe[DIV_LAT-1].neg_r ? f_neg(i_div_remainder) : i_div_remainder;
        end else begin
            w_result = r_pipe[DIV_LAT-1].neg_q ? f_neg(i_div_quotient) : i_div_quotient;
        end
    end

    // Metadata shift register running in lock-step with the divider pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIV_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < DIV_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (i_flush) begin
                for (int i = 0; i < DIV_LAT; i++) begin
                    r_pipe[i].vld <= 1'b0;
                end
            end
        end
    end

    // In-flight credit: counts every op between accept and delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= {OCC_W{1'b0}};
        end else if (i_flush) begin
            r_occ <= {OCC_W{1'b0}};
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Result FIFO; a push at full only ever coincides with a pop of the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {PTR_W{1'b0}};
            r_rptr <= {PTR_W{1'b0}};
            r_cnt  <= {OCC_W{1'b0}};
            for (int i = 0; i < RES_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr <= {PTR_W{1'b0}};
            r_rptr <= {PTR_W{1'b0}};
            r_cnt  <= {OCC_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= '{data: w_result, tag: r_pipe[DIV_LAT-1].tag};
                r_wptr <= (r_wptr == PTR_W'(RES_DEPTH - 1)) ? {PTR_W{1'b0}} : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(RES_DEPTH - 1)) ? {PTR_W{1'b0}} : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + OCC_W'(1);
                2'b01:   r_cnt <= r_cnt - OCC_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    div_fu_ctrl_chk #(.OCC_W(OCC_W), .RES_DEPTH(RES_DEPTH)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_cnt  (r_cnt),
        .i_occ  (r_occ)
    );
endmodule

// Result-buffer overflow and credit-range checks.
module div_fu_ctrl_chk #(
    parameter int OCC_W     = 3,
    parameter int RES_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic             i_push,
    input logic             i_pop,
    input logic [OCC_W-1:0] i_cnt,
    input logic [OCC_W-1:0] i_occ
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && (i_cnt == OCC_W'(RES_DEPTH))));
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
        (i_occ <= OCC_W'(RES_DEPTH)));
endmodule

// File: tb/tb_div_fu_ctrl.sv
// Bench for div_fu_ctrl: behavioural divider, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_div_fu_ctrl;
    localparam int XLEN = 32, DIV_LAT = 3, TAG_W = 6, RES_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    div_fu_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    logic [XLEN-1:0] div_a, div_b, div_q, div_r;
    logic            div_z;
    logic [XLEN-1:0] dq [DIV_LAT];
    logic [XLEN-1:0] dr [DIV_LAT];
    logic            dz [DIV_LAT];

    div_fu_ctrl #(.XLEN(XLEN), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (flush),
        .bus             (bus),
        .o_div_a         (div_a),
        .o_div_b         (div_b),
        .i_div_quotient  (div_q),
        .i_div_remainder (div_r),
        .i_div_by_0      (div_z)
    );

    // Behavioural unsigned divider with DIV_LAT register stages
    always @(posedge clk) begin
        dq[0] <= (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
        dr[0] <= (div_b == 32'd0) ? div_a : div_a % div_b;
        dz[0] <= (div_b == 32'd0);
        for (int i = 1; i < DIV_LAT; i++) begin
            dq[i] <= dq[i-1];
            dr[i] <= dr[i-1];
            dz[i] <= dz[i-1];
        end
    end
    assign div_q = dq[DIV_LAT-1];
    assign div_r = dr[DIV_LAT-1];
    assign div_z = dz[DIV_LAT-1];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [31:0] f_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        int          due;
    } ent_t;

    ent_t inflight[$];
    ent_t mfifo[$];
    int   cyc = 0;

    // Reference model + compare: outputs checked every cycle, state advanced for next edge
    always @(negedge clk) begin
        bit   ev, er;
        ent_t e;
        if (!rst_n) begin
            chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
            chk("rst_resp_tag", 64'(bus.resp_tag), 64'd0);
            inflight.delete();
            mfifo.delete();
        end else begin
            ev = (mfifo.size() > 0);
            er = ((inflight.size() + mfifo.size()) < RES_DEPTH) && !flush;
            chk("req_ready", 64'(bus.req_ready), 64'(er));
            chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
            if (ev) begin
                chk("resp_data", 64'(bus.resp_data), 64'(mfifo[0].res));
                chk("resp_tag", 64'(bus.resp_tag), 64'(mfifo[0].tag));
            end
            if (flush) begin
                inflight.delete();
                mfifo.delete();
            end else begin
                if (ev && bus.resp_ready) void'(mfifo.pop_front());
                while (inflight.size() > 0 && inflight[0].due == cyc + 1) begin
                    mfifo.push_back(inflight.pop_front());
                end
                if (bus.req_valid && er) begin
                    e.res = f_ref(bus.req_op, bus.req_rs1, bus.req_rs2);
                    e.tag = bus.req_tag;
                    e.due = cyc + DIV_LAT + 1;
                    inflight.push_back(e);
                end
            end
        end
        cyc++;
    end

    // All helpers start and end just after a rising edge
    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_tag   = tag;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        int n;
        n = 0;
        drive(op, a, b, tag);
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept_in_time", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int acc;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b01;
        bus.req_rs1    = 32'd0;
        bus.req_rs2    = 32'd1;
        bus.req_tag    = 6'd0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Model pins
        chk("pin_divu", 64'(f_ref(2'b01, 32'd100, 32'd7)), 64'd14);
        chk("pin_remu", 64'(f_ref(2'b11, 32'd100, 32'd7)), 64'd2);
        chk("pin_div_neg", 64'(f_ref(2'b00, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        chk("pin_rem_neg", 64'(f_ref(2'b10, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
        chk("pin_rem_negdiv", 64'(f_ref(2'b10, 32'd7, 32'hFFFF_FFFE)), 64'd1);
        chk("pin_div_min", 64'(f_ref(2'b00, 32'h8000_0000, 32'd2)), 64'hC000_0000);
        chk("pin_div_by0", 64'(f_ref(2'b00, 32'd5, 32'd0)), 64'hFFFF_FFFF);
        chk("pin_remu_by0", 64'(f_ref(2'b11, 32'd5, 32'd0)), 64'd5);
        chk("pin_div_ovf", 64'(f_ref(2'b00, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);
        chk("pin_rem_ovf", 64'(f_ref(2'b10, 32'h8000_0000, 32'hFFFF_FFFF)), 64'd0);

        // Latency: accept in cycle N, response in N+4
        send(2'b01, 32'd100, 32'd7, 6'd5);
        idle(2);
        @(negedge clk);
        chk("lat_n3_valid", 64'(bus.resp_valid), 64'd0);
        idle(1);
        @(negedge clk);
        chk("lat_n4_valid", 64'(bus.resp_valid), 64'd1);
        chk("lat_n4_data", 64'(bus.resp_data), 64'd14);
        chk("lat_n4_tag", 64'(bus.resp_tag), 64'd5);
        idle(2);

        // Arithmetic and special-case stream
        send(2'b11, 32'd100, 32'd7, 6'd6);
        send(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd7);
        send(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd8);
        send(2'b10, 32'd7, 32'hFFFF_FFFE, 6'd9);
        send(2'b00, 32'h8000_0000, 32'd2, 6'd10);
        send(2'b00, 32'd5, 32'd0, 6'd11);
        send(2'b11, 32'd5, 32'd0, 6'd12);
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14);
        send(2'b10, 32'h8000_0000, 32'd3, 6'd15);
        send(2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 6'd16);
        idle(8);

        // Back-pressure: 8 single-cycle requests, only 4 fit
        bus.resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'(i), 32'hFFFF_FF00 + 32'(i * 37), 32'(i + 2), 6'(i));
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) acc++;
            if (i == 4) chk("bp_ready_5th", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(acc), 64'd4);
        idle(6);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_at_pop", 64'(bus.req_ready), 64'd0);
        chk("bp_first_tag", 64'(bus.resp_tag), 64'd0);
        idle(1);
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        chk("bp_second_tag", 64'(bus.resp_tag), 64'd1);
        idle(6);

        // Flush with one buffered and three in flight
        bus.resp_ready = 1'b0;
        send(2'b01, 32'd77, 32'd7, 6'd20);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 32'(40 + i), 32'd4, 6'(21 + i));
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("flush_req_ready", 64'(bus.req_ready), 64'd1);
        idle(6);
        bus.resp_ready = 1'b1;
        send(2'b01, 32'd9, 32'd3, 6'd33);
        idle(2);
        @(negedge clk);
        chk("post_flush_n3_valid", 64'(bus.resp_valid), 64'd0);
        idle(1);
        @(negedge clk);
        chk("post_flush_valid", 64'(bus.resp_valid), 64'd1);
        chk("post_flush_data", 64'(bus.resp_data), 64'd3);
        chk("post_flush_tag", 64'(bus.resp_tag), 64'd33);
        idle(3);

        // Asynchronous reset while a response is held
        bus.resp_ready = 1'b0;
        send(2'b01, 32'd50, 32'd5, 6'd40);
        idle(4);
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
        chk("pre_rst_data", 64'(bus.resp_data), 64'd10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("async_rst_data", 64'(bus.resp_data), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_fu_ctrl.md
Name: div_fu_ctrl

Overview:
- Issue/collect controller for the out-of-order core's divide functional unit. It sits between the reservation station and the pipelined divider instance (unsigned, remainder mode, no stall, fixed latency).
- Accepts RISC-V DIV/DIVU/REM/REMU ops with tags, converts signed operands to magnitudes, and drives the divider. It tracks metadata alongside the divider pipe, applies sign fix-up and spec-mandated special cases, and buffers results for in-order, back-pressured delivery to the CDB arbiter.

Parameters:
XLEN, 32, operand/result width
DIV_LAT, 3, cycles from operands on div_a/div_b (sampled at clock edge) to valid div_quotient/div_remainder
TAG_W, 6, ROB/physical-register tag width
RES_DEPTH, 4, result buffer entries; also the total in-flight credit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all in-flight and buffered ops
req_valid  in  1  request valid
req_ready  out  1  controller can accept
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_rs1  in  XLEN  dividend
req_rs2  in  XLEN  divisor
req_tag  in  TAG_W  destination tag
div_a  out  XLEN  unsigned dividend to divider
div_b  out  XLEN  unsigned divisor to divider
div_quotient  in  XLEN  divider quotient
div_remainder  in  XLEN  divider remainder
div_by_0  in  1  divider zero flag (ignored; zero divisor is handled internally)
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  XLEN  final result
resp_tag  out  TAG_W  tag of result

Behaviour:
- Clock and reset: single clock domain, clk; rst_n is asynchronous and active-low.
- Reset state: metadata pipe valids 0, buffer empty, occupancy 0, resp_valid 0, resp_data 0, resp_tag 0, req_ready 1 after release. Reset mid-operation drops everything immediately.
- Credit counter occ, range 0..RES_DEPTH:
  - +1 on accept (req_valid & req_ready).
  - -1 on pop (resp_valid & resp_ready).
  - Both in the same cycle: no change.
- req_ready = (occ < RES_DEPTH) & !flush. Combinational from registers and flush only; no dependence on req_valid.
- Operand conditioning (combinational, driven every cycle):
  - Signed ops (DIV, REM): div_a = |rs1|, div_b = |rs2|, using two's-complement negation. |0x80000000| = 0x80000000 unsigned.
  - Unsigned ops: pass through.
  - div_a/div_b are don't-care when not accepting.
- Metadata shift register, DIV_LAT stages, advancing every cycle. Per stage: valid, tag, op, neg_q = rs1[msb]^rs2[msb], neg_r = rs1[msb], special flag, special value.
  - Stage 0 loads on accept; otherwise valid 0.
- Special cases, decided at issue:
  - rs2 == 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Final result at pipe exit:
  - If special: special value.
  - DIV: quotient, negated if neg_q.
  - REM: remainder, negated if neg_r.
  - DIVU/REMU: raw quotient/remainder.
- Pipe exit with valid=1 writes {result, tag} into the RES_DEPTH FIFO the same edge. Credit scheme guarantees the FIFO never overflows; an assertion checks this.
- Response:
  - resp_valid = FIFO non-empty; resp_data/resp_tag = FIFO head.
  - Hold stable while resp_valid & !resp_ready.
  - Simultaneous push and pop allowed, including at full and at one entry.
- Latency: accept in cycle N -> resp_valid in cycle N+DIV_LAT+1 when the buffer is empty and resp_ready=1. Throughput 1 op/cycle sustained. Results are strictly in issue order.
- flush (synchronous):
  - Next edge clears all metadata valids, the FIFO, and occ. resp_valid=0 next cycle.
  - No request is accepted while flush=1.
  - Values still inside the divider are ignored because their metadata is gone.

Test Plan:
- DIVU rs1=100 rs2=7 tag=5 accepted cycle N, resp_ready=1 -> resp_valid at N+4, data 14, tag 5. REMU same operands -> 2.
- DIV -7/2 (0xFFFFFFF9, 0x2) -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. REM 7/-2 -> 1. DIV 0x80000000/2 -> 0xC0000000.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Back-pressure: resp_ready=0, 8 back-to-back requests tags 0..7 -> only tags 0..3 accepted, req_ready low from the 5th cycle. Then resp_ready=1 -> tags 0..3 in order, one per cycle, and req_ready returns 1 the cycle after the first pop.
- Flush: 3 ops in flight plus 1 buffered, flush pulse -> no resp_valid for any of them, and req_ready=1 the cycle after. A following DIVU 9/3 returns 3 with correct latency.
- Reset: assert rst_n low asynchronously mid-stream with resp_valid=1 -> resp_valid and resp_data drop to 0 before the next clk edge. After release, req_ready=1 and there are no spurious responses.
